// File: rtl/fifo_rd_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_arb_pkg : shared types and sizing helpers for fifo_rd_arbiter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package fifo_rd_arb_pkg;

  typedef enum logic [0:0] {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  // Channel-id width, never narrower than one bit.
  function automatic int chw(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int bcw(input int burst);
    return $clog2(burst + 1);
  endfunction

  localparam int BURST_DEFAULT = 4;
  localparam int BCW           = $clog2(BURST_DEFAULT + 1);

endpackage
`default_nettype wire

// File: rtl/fifo_rd_arbiter_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rr_arb_pick : combinational channel picker (round-robin, or fixed        |
// | lowest-index priority when FIFO_RD_ARB_FIXED_PRIO_EN is defined)         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module rr_arb_pick
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CHW    = chw(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CHW-1:0]    last_grant,
  output logic [CHW-1:0]    gnt_idx,
  output logic              any_req
);

  assign any_req = |req;

`ifdef FIFO_RD_ARB_FIXED_PRIO_EN
  logic w_unused_last_grant;
  assign w_unused_last_grant = ^last_grant;

  // Descending scan so the lowest requesting index is the final winner.
  always_comb begin
    gnt_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (req[i]) gnt_idx = CHW'(i);
    end
  end
`else
  int   w_idx;
  logic w_found;

  // Scan starts just after the previous winner and wraps modulo NUM_CH.
  always_comb begin
    gnt_idx = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int off = 1; off <= NUM_CH; off++) begin
      w_idx = (int'(last_grant) + off) % NUM_CH;
      if (!w_found && req[w_idx]) begin
        gnt_idx = CHW'(w_idx);
        w_found = 1'b1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: rtl/fifo_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_arbiter : drains NUM_CH FIFO read ports in bursts of up to BURST |
// | words into one registered valid/ready stage. Option macro:               |
// | FIFO_RD_ARB_FIXED_PRIO_EN (fixed priority instead of round-robin).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module fifo_rd_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DWIDTH = 8,
  parameter int BURST  = 4,
  localparam int CHW   = chw(NUM_CH)
) (
  input  logic                     rclk,
  input  logic                     rrstn,
  input  logic [NUM_CH-1:0]        rempty,
  input  logic [NUM_CH*DWIDTH-1:0] rdata,
  output logic [NUM_CH-1:0]        rpop,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DWIDTH-1:0]        m_data,
  output logic [CHW-1:0]           m_ch
);

  localparam int             c_bcw      = bcw(BURST);
  localparam logic [c_bcw-1:0] c_burst    = c_bcw'(BURST);
  localparam logic [c_bcw-1:0] c_burst_m1 = c_bcw'(BURST - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [CHW-1:0]      r_grant;
  logic [CHW-1:0]      r_last_grant;
  logic [c_bcw-1:0]    r_burst_cnt;
  logic                r_m_valid;
  logic [DWIDTH-1:0]   r_m_data;
  logic [CHW-1:0]      r_m_ch;
  logic                w_ld;
  logic                w_pop;
  logic                w_done;
  logic [CHW-1:0]      w_gnt_idx;
  logic                w_any_req;
  logic [DWIDTH-1:0]   w_head;

  rr_arb_pick #(
    .NUM_CH (NUM_CH),
    .CHW    (CHW)
  ) u_pick (
    .req        (~rempty),
    .last_grant (r_last_grant),
    .gnt_idx    (w_gnt_idx),
    .any_req    (w_any_req)
  );

  assign w_ld   = ~r_m_valid | m_ready;
  assign w_head = rdata[int'(r_grant) * DWIDTH +: DWIDTH];

  always_ff @(posedge rclk) begin
    if (!rrstn) r_state <= ARB;
    else        r_state <= w_next_state;
  end

  // Burst termination is only judged on cycles the output stage can load.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ARB: begin
        if (w_any_req) w_next_state = XFER;
      end
      XFER: begin
        w_pop  = rrstn & w_ld & ~rempty[r_grant] & (r_burst_cnt < c_burst);
        w_done = w_ld & ((w_pop & (r_burst_cnt == c_burst_m1)) | rempty[r_grant]);
        if (w_done) w_next_state = ARB;
      end
      default: w_next_state = ARB;
    endcase
  end

  assign rpop = w_pop ? (NUM_CH'(1) << r_grant) : '0;

  always_ff @(posedge rclk) begin
    if (!rrstn) begin
      r_grant      <= '0;
      r_last_grant <= CHW'(NUM_CH - 1);
      r_burst_cnt  <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_ch       <= '0;
    end else begin
      if (r_state == ARB && w_any_req) begin
        r_grant     <= w_gnt_idx;
        r_burst_cnt <= '0;
      end
      if (w_pop) begin
        r_m_data    <= w_head;
        r_m_ch      <= r_grant;
        r_m_valid   <= 1'b1;
        r_burst_cnt <= r_burst_cnt + c_bcw'(1);
      end else if (w_ld) begin
        r_m_valid <= 1'b0;
      end
      if (r_state == XFER && w_done) r_last_grant <= r_grant;
    end
  end

  assign m_valid = r_m_valid;
  assign m_data  = r_m_data;
  assign m_ch    = r_m_ch;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_arbiter : directed self-checking bench for fifo_rd_arbiter    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_arbiter;

  logic        rclk = 1'b0;
  logic        rrstn = 1'b0;
  logic        m_ready = 1'b1;
  logic [3:0]  rempty;
  logic [31:0] rdata;
  logic [3:0]  rpop;
  logic        m_valid;
  logic [7:0]  m_data;
  logic [1:0]  m_ch;

  logic [7:0] mem [4][64];
  int head [4];
  int tail [4];
  int out_seq [4];
  int total = 0;
  int bad = 0;
  int npop = 0;

  always #5 rclk = ~rclk;

  fifo_rd_arbiter #(
    .NUM_CH (4),
    .DWIDTH (8),
    .BURST  (4)
  ) dut (
    .rclk    (rclk),
    .rrstn   (rrstn),
    .rempty  (rempty),
    .rdata   (rdata),
    .rpop    (rpop),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_ch    (m_ch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      rempty[i]        = (head[i] == tail[i]);
      rdata[i*8 +: 8]  = mem[i][head[i] & 63];
    end
  endtask

  // Words are tagged {channel, per-channel sequence number}.
  task automatic load(input int ch, input int n);
    logic [1:0] c;
    logic [5:0] s;
    for (int k = 0; k < n; k++) begin
      c = ch[1:0];
      s = tail[ch][5:0];
      mem[ch][tail[ch]] = {c, s};
      tail[ch]++;
    end
    refresh();
  endtask

  task automatic tick();
    logic [3:0] p;
    logic       v, r, rs;
    logic [7:0] d;
    logic [1:0] c;
    int         t;
    logic [5:0] s;
    #1;
    p  = rpop;
    v  = m_valid;
    r  = m_ready;
    d  = m_data;
    c  = m_ch;
    rs = rrstn;
    chk("onehot_pop", {31'd0, $onehot0(p)}, 32'd1);
    @(posedge rclk);
    #1;
    for (int i = 0; i < 4; i++) if (p[i]) head[i]++;
    npop += $countones(p);
    if (!rs) begin
      for (int i = 0; i < 4; i++) out_seq[i] = head[i];
    end else if (v && r) begin
      t = out_seq[c];
      s = t[5:0];
      chk("scoreboard", {24'd0, d}, {24'd0, c, s});
      out_seq[c]++;
    end
    refresh();
  endtask

  task automatic do_reset();
    rrstn = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
      out_seq[i] = 0;
    end
    refresh();
    tick();
    rrstn = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
      out_seq[i] = 0;
    end
    refresh();

    // Reset values
    rrstn = 1'b0;
    m_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_data", {24'd0, m_data}, 32'd0);
    chk("rst_ch", {30'd0, m_ch}, 32'd0);
    load(2, 10);
    #1 chk("rst_pop", {28'd0, rpop}, 32'd0);

    // Reset in the middle of a ch2 burst
    rrstn = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_valid", {31'd0, m_valid}, 32'd1);
    chk("mid_data", {24'd0, m_data}, 32'h81);
    chk("mid_ch", {30'd0, m_ch}, 32'd2);
    load(0, 4);
    rrstn = 1'b0;
    #1 chk("mid_rst_pop", {28'd0, rpop}, 32'd0);
    tick();
    chk("mid_rst_valid", {31'd0, m_valid}, 32'd0);
    rrstn = 1'b1;
    tick();
    #1 chk("post_rst_pop", {28'd0, rpop}, 32'b0001);
    tick();
    chk("post_rst_valid", {31'd0, m_valid}, 32'd1);
    chk("post_rst_ch", {30'd0, m_ch}, 32'd0);
    chk("post_rst_data", {24'd0, m_data}, 32'h00);

`ifndef FIFO_RD_ARB_FIXED_PRIO_EN
    // Round-robin over four full channels: 4 words then one arbitration gap
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 10);
    npop = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      if ((k % 5) == 1) begin
        chk("rr_gap_valid", {31'd0, m_valid}, 32'd0);
      end else begin
        chk("rr_valid", {31'd0, m_valid}, 32'd1);
        chk("rr_ch", {30'd0, m_ch}, 32'(((k - 2) / 5) % 4));
      end
    end
    chk("rr_npop", npop, 32'd20);
`else
    // Fixed priority: ch0 always wins over ch3, still in bursts of 4
    do_reset();
    load(0, 10);
    load(3, 10);
    npop = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if ((k % 5) == 1) begin
        chk("fp_gap_valid", {31'd0, m_valid}, 32'd0);
      end else begin
        chk("fp_valid", {31'd0, m_valid}, 32'd1);
        chk("fp_ch", {30'd0, m_ch}, 32'd0);
      end
    end
    chk("fp_npop", npop, 32'd8);
`endif

    // Short channel: ch1 holds two words only
    do_reset();
    load(1, 2);
    npop = 0;
    tick();
    tick();
    tick();
    chk("short_ch", {30'd0, m_ch}, 32'd1);
    chk("short_data", {24'd0, m_data}, 32'h41);
    #1 chk("short_empty_pop", {28'd0, rpop}, 32'd0);
    tick();
    chk("short_gap_valid", {31'd0, m_valid}, 32'd0);
    for (int k = 0; k < 4; k++) tick();
    chk("short_npop", npop, 32'd2);
    chk("short_idle_valid", {31'd0, m_valid}, 32'd0);
    load(1, 1);
    tick();
    #1 chk("short_refill_pop", {28'd0, rpop}, 32'b0010);
    tick();
    chk("short_refill_ch", {30'd0, m_ch}, 32'd1);
    chk("short_refill_data", {24'd0, m_data}, 32'h42);

    // Backpressure for five cycles mid-burst
    do_reset();
    load(0, 8);
    tick();
    tick();
    tick();
    chk("bp_data0", {24'd0, m_data}, 32'h01);
    m_ready = 1'b0;
    npop = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_hold_data", {24'd0, m_data}, 32'h01);
      chk("bp_hold_ch", {30'd0, m_ch}, 32'd0);
    end
    chk("bp_npop", npop, 32'd0);
    m_ready = 1'b1;
    tick();
    chk("bp_resume_data", {24'd0, m_data}, 32'h02);
    tick();
    chk("bp_last_data", {24'd0, m_data}, 32'h03);
    tick();
    chk("bp_gap_valid", {31'd0, m_valid}, 32'd0);
    tick();
    chk("bp_next_data", {24'd0, m_data}, 32'h04);

    // Wrap-around between ch0 and ch3
    do_reset();
    load(0, 2);
    load(3, 2);
    tick();
    tick();
    tick();
    chk("wrap_ch0", {30'd0, m_ch}, 32'd0);
    chk("wrap_data0", {24'd0, m_data}, 32'h01);
    tick();
    tick();
    tick();
    chk("wrap_ch3", {30'd0, m_ch}, 32'd3);
    chk("wrap_data3", {24'd0, m_data}, 32'hC0);
    tick();
    tick();
    load(0, 1);
    load(3, 1);
    tick();
    tick();
    chk("wrap_back_ch", {30'd0, m_ch}, 32'd0);
    chk("wrap_back_data", {24'd0, m_data}, 32'h02);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
